// File: rtl/fps_seq.sv
// fps_seq: FPU control sequencer.
// Takes a start request from the CPU, then fetches WORDS operand words
// (memory handshake or register file). It pulses the datapath with
// strob1/strob2 pairs for the execute and normalisation steps, writes the
// result back word by word and finishes with a one-cycle ekc_fp pulse.
//
// Ports:
//   clk_i          system clock
//   clr_i          synchronous active-high reset
//   efp_i          start request (sampled in IDLE only)
//   op_i[1:0]      00 add/sub, 01 mul, 10 div, 11 normalise-only
//   nrf_i          operands come from the register file
//   fwz_i          zero operand (sampled when the last operand word ends)
//   ok_i           memory acknowledge, one per word
//   nz_i           mantissa not yet normalised
//   ovf_i          datapath overflow (sampled in strob2 cycles)
//   busy_o         high in every state except IDLE
//   read_fp_o      memory read request
//   rlp_fp_o       register-file access at word lp_o
//   wr_fp_o        register write (STORE)
//   zero_fp_o      write zeros (STORE after a zero operand)
//   strob1_fp_o    first datapath strobe of a step
//   strob2_fp_o    second datapath strobe of a step
//   lp_o           current word index
//   ekc_fp_o       done pulse
//   err_fp_o       overflow or normalisation-limit error (sticky)
module fps_seq #(
   parameter int WORDS    = 3,
   parameter int LPW      = 2,
   parameter int NORM_MAX = 40
) (
   input  logic           clk_i,
   input  logic           clr_i,
   input  logic           efp_i,
   input  logic [1:0]     op_i,
   input  logic           nrf_i,
   input  logic           fwz_i,
   input  logic           ok_i,
   input  logic           nz_i,
   input  logic           ovf_i,
   output logic           busy_o,
   output logic           read_fp_o,
   output logic           rlp_fp_o,
   output logic           wr_fp_o,
   output logic           zero_fp_o,
   output logic           strob1_fp_o,
   output logic           strob2_fp_o,
   output logic [LPW-1:0] lp_o,
   output logic           ekc_fp_o,
   output logic           err_fp_o
);

   localparam int EW = $clog2(16 * WORDS + 1);
   localparam int SW = $clog2(NORM_MAX + 1);

   localparam logic [LPW-1:0] LP_LAST  = LPW'(WORDS - 1);
   localparam logic [EW-1:0]  E_ADD    = EW'(1);
   localparam logic [EW-1:0]  E_MULDIV = EW'(16 * WORDS);
   localparam logic [SW-1:0]  S_MAX    = SW'(NORM_MAX);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_RDREG, S_CHK, S_EX1, S_EX2,
      S_NCHK, S_NS1, S_NS2, S_STORE, S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [LPW-1:0] lp_q, lp_d;
   logic [EW-1:0]  e_q, e_d;
   logic [SW-1:0]  s_q, s_d;
   logic [SW-1:0]  s_inc;
   logic [1:0]     op_q, op_d;
   logic           err_q, err_d;
   logic           zf_q, zf_d;

   logic busy_q, read_q, rlp_q, wr_q, zero_q, strob1_q, strob2_q, ekc_q;

   // Operand check. It is evaluated on the edge that ends the last operand
   // word, so it never costs a cycle of its own; this keeps the execute
   // strobes directly behind the fetch.
   state_t        chk_state;
   logic [EW-1:0] chk_e;
   logic          chk_zf;

   always_comb begin
      chk_state = S_EX1;
      chk_e     = e_q;
      chk_zf    = 1'b0;
      if (fwz_i) begin
         chk_state = S_STORE;
         chk_zf    = 1'b1;
      end else if (op_q == 2'b11) begin
         chk_state = S_NCHK;
      end else begin
         chk_e = (op_q == 2'b00) ? E_ADD : E_MULDIV;
      end
   end

   assign s_inc = s_q + 1'b1;

   always_comb begin
      state_d = state_q;
      lp_d    = lp_q;
      e_d     = e_q;
      s_d     = s_q;
      op_d    = op_q;
      err_d   = err_q;
      zf_d    = zf_q;
      case (state_q)
         S_IDLE: begin
            if (efp_i) begin
               op_d    = op_i;
               lp_d    = '0;
               e_d     = '0;
               s_d     = '0;
               err_d   = 1'b0;
               zf_d    = 1'b0;
               state_d = nrf_i ? S_RDREG : S_FETCH;
            end
         end
         S_FETCH: begin
            if (ok_i) begin
               if (lp_q == LP_LAST) begin
                  lp_d    = '0;
                  state_d = chk_state;
                  e_d     = chk_e;
                  zf_d    = chk_zf;
               end else begin
                  lp_d = lp_q + 1'b1;
               end
            end
         end
         S_RDREG: begin
            if (lp_q == LP_LAST) begin
               lp_d    = '0;
               state_d = chk_state;
               e_d     = chk_e;
               zf_d    = chk_zf;
            end else begin
               lp_d = lp_q + 1'b1;
            end
         end
         S_CHK: begin
            state_d = chk_state;
            e_d     = chk_e;
            zf_d    = chk_zf;
         end
         S_EX1: state_d = S_EX2;
         S_EX2: begin
            if (ovf_i) err_d = 1'b1;
            e_d     = e_q - 1'b1;
            state_d = (e_q == E_ADD) ? S_NCHK : S_EX1;
         end
         S_NCHK: state_d = nz_i ? S_NS1 : S_STORE;
         S_NS1:  state_d = S_NS2;
         S_NS2: begin
            if (ovf_i) err_d = 1'b1;
            s_d = s_inc;
            if (nz_i && (s_inc < S_MAX)) begin
               state_d = S_NS1;
            end else begin
               // Still not normalised after the last permitted shift.
               if (nz_i) err_d = 1'b1;
               state_d = S_STORE;
            end
         end
         S_STORE: begin
            if (lp_q == LP_LAST) begin
               lp_d    = '0;
               state_d = S_DONE;
            end else begin
               lp_d = lp_q + 1'b1;
            end
         end
         S_DONE: begin
            lp_d    = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are flops aligned with
   // the state they describe.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q  <= S_IDLE;
         lp_q     <= '0;
         e_q      <= '0;
         s_q      <= '0;
         op_q     <= 2'b00;
         err_q    <= 1'b0;
         zf_q     <= 1'b0;
         busy_q   <= 1'b0;
         read_q   <= 1'b0;
         rlp_q    <= 1'b0;
         wr_q     <= 1'b0;
         zero_q   <= 1'b0;
         strob1_q <= 1'b0;
         strob2_q <= 1'b0;
         ekc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lp_q     <= lp_d;
         e_q      <= e_d;
         s_q      <= s_d;
         op_q     <= op_d;
         err_q    <= err_d;
         zf_q     <= zf_d;
         busy_q   <= (state_d != S_IDLE);
         read_q   <= (state_d == S_FETCH);
         rlp_q    <= (state_d == S_RDREG) || (state_d == S_STORE);
         wr_q     <= (state_d == S_STORE);
         zero_q   <= (state_d == S_STORE) && zf_d;
         strob1_q <= (state_d == S_EX1) || (state_d == S_NS1);
         strob2_q <= (state_d == S_EX2) || (state_d == S_NS2);
         ekc_q    <= (state_d == S_DONE);
      end
   end

   assign busy_o      = busy_q;
   assign read_fp_o   = read_q;
   assign rlp_fp_o    = rlp_q;
   assign wr_fp_o     = wr_q;
   assign zero_fp_o   = zero_q;
   assign strob1_fp_o = strob1_q;
   assign strob2_fp_o = strob2_q;
   assign lp_o        = lp_q;
   assign ekc_fp_o    = ekc_q;
   assign err_fp_o    = err_q;

endmodule

// File: tb/tb_fps_seq.sv
module tb_fps_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       clr, efp, nrf, fwz, ok, nz, ovf;
   logic [1:0] op;

   // Three-word instance
   logic       a_busy, a_read, a_rlp, a_wr, a_zero, a_s1, a_s2, a_ekc, a_err;
   logic [1:0] a_lp;
   // Two-word instance
   logic       b_busy, b_read, b_rlp, b_wr, b_zero, b_s1, b_s2, b_ekc, b_err;
   logic [0:0] b_lp;

   fps_seq #(.WORDS(3), .LPW(2), .NORM_MAX(40)) u_dut3 (
      .clk_i(clk), .clr_i(clr), .efp_i(efp), .op_i(op), .nrf_i(nrf),
      .fwz_i(fwz), .ok_i(ok), .nz_i(nz), .ovf_i(ovf),
      .busy_o(a_busy), .read_fp_o(a_read), .rlp_fp_o(a_rlp), .wr_fp_o(a_wr),
      .zero_fp_o(a_zero), .strob1_fp_o(a_s1), .strob2_fp_o(a_s2),
      .lp_o(a_lp), .ekc_fp_o(a_ekc), .err_fp_o(a_err)
   );

   fps_seq #(.WORDS(2), .LPW(1), .NORM_MAX(40)) u_dut2 (
      .clk_i(clk), .clr_i(clr), .efp_i(efp), .op_i(op), .nrf_i(nrf),
      .fwz_i(fwz), .ok_i(ok), .nz_i(nz), .ovf_i(ovf),
      .busy_o(b_busy), .read_fp_o(b_read), .rlp_fp_o(b_rlp), .wr_fp_o(b_wr),
      .zero_fp_o(b_zero), .strob1_fp_o(b_s1), .strob2_fp_o(b_s2),
      .lp_o(b_lp), .ekc_fp_o(b_ekc), .err_fp_o(b_err)
   );

   localparam int R_BUSY = 0, R_READ = 1, R_RLP = 2, R_WR = 3, R_ZERO = 4;
   localparam int R_S1 = 5, R_S2 = 6, R_EKC = 7, R_ERR = 8;

   int checks = 0;
   int passed = 0;

   // Per-cycle record of the selected instance; cycle n follows edge n-1.
   logic rec [0:8][0:255];
   int   rec_lp [0:255];
   int   ekc_cyc, ekc_cnt;

   // Stimulus knobs, cycle numbers; 0 means "never".
   logic [255:0] ok_vec;
   int nz_until, ovf_at, efp_at, clr_at;

   task automatic clear_knobs();
      ok_vec = '0; nz_until = 0; ovf_at = 0; efp_at = 0; clr_at = 0;
   endtask

   task automatic run_seq(input string name, input bit w2, input bit pre_clr,
                          input logic nrf_v, input logic [1:0] op_v,
                          input logic fwz_v, input int ncyc);
      for (int s = 0; s < 9; s++)
         for (int c = 0; c < 256; c++) rec[s][c] = 1'b0;
      for (int c = 0; c < 256; c++) rec_lp[c] = 0;
      efp = 1'b0; ok = 1'b0; nz = 1'b0; ovf = 1'b0;
      nrf = nrf_v; op = op_v; fwz = fwz_v;
      if (pre_clr) begin
         clr = 1'b1;
         @(posedge clk); #1;
      end
      clr = 1'b0; efp = 1'b1;
      @(posedge clk);                       // edge 0
      ekc_cyc = -1; ekc_cnt = 0;
      for (int c = 1; c <= ncyc; c++) begin
         #1;
         if (w2) begin
            rec[R_BUSY][c] = b_busy; rec[R_READ][c] = b_read; rec[R_RLP][c] = b_rlp;
            rec[R_WR][c] = b_wr; rec[R_ZERO][c] = b_zero; rec[R_S1][c] = b_s1;
            rec[R_S2][c] = b_s2; rec[R_EKC][c] = b_ekc; rec[R_ERR][c] = b_err;
            rec_lp[c] = int'(b_lp);
         end else begin
            rec[R_BUSY][c] = a_busy; rec[R_READ][c] = a_read; rec[R_RLP][c] = a_rlp;
            rec[R_WR][c] = a_wr; rec[R_ZERO][c] = a_zero; rec[R_S1][c] = a_s1;
            rec[R_S2][c] = a_s2; rec[R_EKC][c] = a_ekc; rec[R_ERR][c] = a_err;
            rec_lp[c] = int'(a_lp);
         end
         if (rec[R_EKC][c] === 1'b1) begin
            ekc_cnt++;
            if (ekc_cyc < 0) ekc_cyc = c;
         end
         efp = (c == efp_at);
         ok  = ok_vec[c];
         nz  = (c < nz_until);
         ovf = (c == ovf_at);
         clr = (c == clr_at);
         @(posedge clk);
      end
      #1;
      clr = 1'b0; efp = 1'b0; ok = 1'b0; ovf = 1'b0; nz = 1'b0;
      $display("run %s: words=%0d nrf=%0b op=%0d fwz=%0b first_ekc=%0d ekc_count=%0d",
               name, w2 ? 2 : 3, nrf_v, op_v, fwz_v, ekc_cyc, ekc_cnt);
   endtask

   function automatic int cnt(input int s, input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) if (rec[s][c] === 1'b1) n++;
      return n;
   endfunction

   function automatic int first_hi(input int s, input int hi);
      for (int c = 1; c <= hi; c++) if (rec[s][c] === 1'b1) return c;
      return -1;
   endfunction

   function automatic int last_hi(input int s, input int hi);
      int l = -1;
      for (int c = 1; c <= hi; c++) if (rec[s][c] === 1'b1) l = c;
      return l;
   endfunction

   // Strobe overlap, or a strob2 not directly after a strob1, or vice versa.
   function automatic int strobe_bad(input int hi);
      int n = 0;
      for (int c = 1; c < hi; c++) begin
         if (rec[R_S1][c] && rec[R_S2][c]) n++;
         if (rec[R_S2][c] && !rec[R_S1][c-1]) n++;
         if (rec[R_S1][c] && !rec[R_S2][c+1]) n++;
      end
      return n;
   endfunction

   task automatic test_reset();
      logic [10:0] v3;
      logic [9:0]  v2;
      clr = 1'b1; efp = 1'b1; nrf = 1'b1; op = 2'b01; fwz = 1'b0;
      ok = 1'b1; nz = 1'b1; ovf = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      v3 = {a_busy, a_read, a_rlp, a_wr, a_zero, a_s1, a_s2, a_ekc, a_err, a_lp};
      v2 = {b_busy, b_read, b_rlp, b_wr, b_zero, b_s1, b_s2, b_ekc, b_err, b_lp};
      checks++; if (v3 !== 11'd0) $display("FAIL reset_outputs_w3: got %b want 0", v3); else passed++;
      checks++; if (v2 !== 10'd0) $display("FAIL reset_outputs_w2: got %b want 0", v2); else passed++;
      clr = 1'b0; efp = 1'b0; ok = 1'b0; nz = 1'b0; ovf = 1'b0;
      $display("run reset: clr with efp held");
   endtask

   task automatic test_add_reg();
      clear_knobs();
      run_seq("add_reg", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 14);
      checks++; if (cnt(R_RLP, 1, 3) !== 3) $display("FAIL add_rlp_fetch: got %0d want 3", cnt(R_RLP, 1, 3)); else passed++;
      checks++; if ({rec_lp[1], rec_lp[2], rec_lp[3]} !== {32'd0, 32'd1, 32'd2})
         $display("FAIL add_lp_fetch: got %0d,%0d,%0d want 0,1,2", rec_lp[1], rec_lp[2], rec_lp[3]); else passed++;
      checks++; if (first_hi(R_S1, 14) !== 4 || cnt(R_S1, 1, 14) !== 1)
         $display("FAIL add_strob1: got first %0d count %0d want 4/1", first_hi(R_S1, 14), cnt(R_S1, 1, 14)); else passed++;
      checks++; if (first_hi(R_S2, 14) !== 5 || cnt(R_S2, 1, 14) !== 1)
         $display("FAIL add_strob2: got first %0d count %0d want 5/1", first_hi(R_S2, 14), cnt(R_S2, 1, 14)); else passed++;
      checks++; if (first_hi(R_WR, 14) !== 7 || last_hi(R_WR, 14) !== 9 || cnt(R_WR, 1, 14) !== 3)
         $display("FAIL add_wr: got %0d..%0d want 7..9", first_hi(R_WR, 14), last_hi(R_WR, 14)); else passed++;
      checks++; if ({rec_lp[7], rec_lp[8], rec_lp[9]} !== {32'd0, 32'd1, 32'd2})
         $display("FAIL add_lp_store: got %0d,%0d,%0d want 0,1,2", rec_lp[7], rec_lp[8], rec_lp[9]); else passed++;
      checks++; if (ekc_cyc !== 10 || ekc_cnt !== 1)
         $display("FAIL add_ekc: got cycle %0d count %0d want 10/1", ekc_cyc, ekc_cnt); else passed++;
      checks++; if (rec[R_ERR][10] !== 1'b0 || cnt(R_ZERO, 1, 14) !== 0)
         $display("FAIL add_err_zero: got err %b zero %0d want 0/0", rec[R_ERR][10], cnt(R_ZERO, 1, 14)); else passed++;
      checks++; if (rec[R_BUSY][10] !== 1'b1 || rec[R_BUSY][11] !== 1'b0 || rec_lp[11] !== 0)
         $display("FAIL add_idle_after: got busy %b/%b lp %0d want 1/0/0", rec[R_BUSY][10], rec[R_BUSY][11], rec_lp[11]); else passed++;
   endtask

   task automatic test_fetch();
      clear_knobs();
      ok_vec[3] = 1'b1; ok_vec[4] = 1'b1; ok_vec[8] = 1'b1; ok_vec[12] = 1'b1;
      run_seq("fetch_waits", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 20);
      checks++; if (first_hi(R_READ, 20) !== 1 || last_hi(R_READ, 20) !== 8 || cnt(R_READ, 1, 20) !== 8)
         $display("FAIL fetch_read: got %0d..%0d want 1..8", first_hi(R_READ, 20), last_hi(R_READ, 20)); else passed++;
      checks++; if ({rec_lp[3], rec_lp[4], rec_lp[8]} !== {32'd0, 32'd1, 32'd2})
         $display("FAIL fetch_lp_at_ack: got %0d,%0d,%0d want 0,1,2", rec_lp[3], rec_lp[4], rec_lp[8]); else passed++;
      checks++; if (cnt(R_RLP, 1, 8) !== 0) $display("FAIL fetch_no_rlp: got %0d want 0", cnt(R_RLP, 1, 8)); else passed++;
      checks++; if (first_hi(R_S1, 20) !== 9 || first_hi(R_WR, 20) !== 12 || cnt(R_WR, 1, 20) !== 3)
         $display("FAIL fetch_exec_store: got s1 %0d wr %0d/%0d want 9/12/3", first_hi(R_S1, 20), first_hi(R_WR, 20), cnt(R_WR, 1, 20)); else passed++;
      checks++; if (ekc_cyc !== 15 || ekc_cnt !== 1)
         $display("FAIL fetch_ekc: got cycle %0d count %0d want 15/1", ekc_cyc, ekc_cnt); else passed++;
   endtask

   task automatic test_mul();
      clear_knobs();
      run_seq("mul_w2", 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 75);
      checks++; if (cnt(R_S1, 1, 75) !== 32 || cnt(R_S2, 1, 75) !== 32)
         $display("FAIL mul_pairs: got %0d/%0d want 32/32", cnt(R_S1, 1, 75), cnt(R_S2, 1, 75)); else passed++;
      checks++; if (first_hi(R_S1, 75) !== 3 || last_hi(R_S2, 75) !== 66)
         $display("FAIL mul_span: got %0d..%0d want 3..66", first_hi(R_S1, 75), last_hi(R_S2, 75)); else passed++;
      checks++; if (strobe_bad(75) !== 0) $display("FAIL mul_strobe_order: got %0d want 0", strobe_bad(75)); else passed++;
      checks++; if (ekc_cyc !== 70 || ekc_cnt !== 1 || rec[R_ERR][70] !== 1'b0)
         $display("FAIL mul_ekc: got cycle %0d count %0d err %b want 70/1/0", ekc_cyc, ekc_cnt, rec[R_ERR][70]); else passed++;
      clear_knobs();
      run_seq("div_w2", 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 75);
      checks++; if (cnt(R_S1, 1, 75) !== 32 || ekc_cyc !== 70)
         $display("FAIL div_pairs_ekc: got %0d pairs ekc %0d want 32/70", cnt(R_S1, 1, 75), ekc_cyc); else passed++;
   endtask

   task automatic test_norm();
      clear_knobs();
      nz_until = 10;
      run_seq("norm_3", 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 20);
      checks++; if (cnt(R_S1, 1, 20) !== 3 || cnt(R_S2, 1, 20) !== 3 || first_hi(R_S1, 20) !== 5)
         $display("FAIL norm3_pairs: got %0d/%0d first %0d want 3/3/5", cnt(R_S1, 1, 20), cnt(R_S2, 1, 20), first_hi(R_S1, 20)); else passed++;
      checks++; if (ekc_cyc !== 14 || rec[R_ERR][14] !== 1'b0 || first_hi(R_WR, 20) !== 11)
         $display("FAIL norm3_ekc: got ekc %0d err %b wr %0d want 14/0/11", ekc_cyc, rec[R_ERR][14], first_hi(R_WR, 20)); else passed++;
      clear_knobs();
      nz_until = 1000;
      run_seq("norm_stuck", 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 95);
      checks++; if (cnt(R_S1, 1, 95) !== 40 || cnt(R_S2, 1, 95) !== 40)
         $display("FAIL normmax_pairs: got %0d/%0d want 40/40", cnt(R_S1, 1, 95), cnt(R_S2, 1, 95)); else passed++;
      checks++; if (strobe_bad(95) !== 0) $display("FAIL normmax_strobe_order: got %0d want 0", strobe_bad(95)); else passed++;
      checks++; if (ekc_cyc !== 88 || rec[R_ERR][84] !== 1'b0 || rec[R_ERR][88] !== 1'b1)
         $display("FAIL normmax_err: got ekc %0d err %b/%b want 88/0/1", ekc_cyc, rec[R_ERR][84], rec[R_ERR][88]); else passed++;
      checks++; if (rec[R_ERR][89] !== 1'b1 || rec[R_BUSY][89] !== 1'b0)
         $display("FAIL normmax_err_held: got err %b busy %b want 1/0", rec[R_ERR][89], rec[R_BUSY][89]); else passed++;
   endtask

   task automatic test_zero();
      clear_knobs();
      run_seq("zero_op", 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 12);
      checks++; if (cnt(R_S1, 1, 12) + cnt(R_S2, 1, 12) !== 0)
         $display("FAIL zero_no_strobes: got %0d want 0", cnt(R_S1, 1, 12) + cnt(R_S2, 1, 12)); else passed++;
      checks++; if (first_hi(R_ZERO, 12) !== 4 || cnt(R_ZERO, 1, 12) !== 3 || first_hi(R_WR, 12) !== 4 || cnt(R_WR, 1, 12) !== 3)
         $display("FAIL zero_store: got zero %0d/%0d wr %0d/%0d want 4/3/4/3",
                  first_hi(R_ZERO, 12), cnt(R_ZERO, 1, 12), first_hi(R_WR, 12), cnt(R_WR, 1, 12)); else passed++;
      checks++; if (ekc_cyc !== 7 || ekc_cnt !== 1)
         $display("FAIL zero_ekc: got cycle %0d count %0d want 7/1", ekc_cyc, ekc_cnt); else passed++;
   endtask

   task automatic test_ovf();
      clear_knobs();
      ovf_at = 5;
      run_seq("ovf_ex2", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 14);
      checks++; if (ekc_cyc !== 10 || rec[R_ERR][5] !== 1'b0 || rec[R_ERR][6] !== 1'b1 || rec[R_ERR][11] !== 1'b1)
         $display("FAIL ovf_err: got ekc %0d err %b/%b/%b want 10/0/1/1",
                  ekc_cyc, rec[R_ERR][5], rec[R_ERR][6], rec[R_ERR][11]); else passed++;
      clear_knobs();
      run_seq("after_ovf", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 14);
      checks++; if (rec[R_ERR][1] !== 1'b0 || rec[R_ERR][10] !== 1'b0 || ekc_cyc !== 10)
         $display("FAIL ovf_cleared_on_start: got err %b/%b ekc %0d want 0/0/10", rec[R_ERR][1], rec[R_ERR][10], ekc_cyc); else passed++;
      clear_knobs();
      ovf_at = 4;
      run_seq("ovf_ex1", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 14);
      checks++; if (rec[R_ERR][10] !== 1'b0) $display("FAIL ovf_in_strob1_ignored: got %b want 0", rec[R_ERR][10]); else passed++;
   endtask

   task automatic test_abort();
      int ones;
      clear_knobs();
      clr_at = 4;
      run_seq("abort_mul", 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 80);
      ones = rec_lp[5];
      for (int s = 0; s < 9; s++) ones += int'(rec[s][5]);
      checks++; if (rec[R_S2][4] !== 1'b1 || ones !== 0)
         $display("FAIL abort_outputs: got strob2@4 %b active@5 %0d want 1/0", rec[R_S2][4], ones); else passed++;
      checks++; if (ekc_cnt !== 0 || cnt(R_BUSY, 5, 80) !== 0 || cnt(R_S1, 5, 80) !== 0)
         $display("FAIL abort_quiet: got ekc %0d busy %0d strob1 %0d want 0/0/0",
                  ekc_cnt, cnt(R_BUSY, 5, 80), cnt(R_S1, 5, 80)); else passed++;
      clear_knobs();
      run_seq("add_after_abort", 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 12);
      checks++; if (ekc_cyc !== 8 || cnt(R_WR, 1, 12) !== 2 || cnt(R_S1, 1, 12) !== 1)
         $display("FAIL abort_then_add: got ekc %0d wr %0d s1 %0d want 8/2/1", ekc_cyc, cnt(R_WR, 1, 12), cnt(R_S1, 1, 12)); else passed++;
   endtask

   task automatic test_back_to_back();
      clear_knobs();
      efp_at = 5;
      run_seq("efp_busy", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 16);
      checks++; if (ekc_cnt !== 1 || cnt(R_BUSY, 11, 16) !== 0)
         $display("FAIL efp_while_busy: got ekc %0d busy %0d want 1/0", ekc_cnt, cnt(R_BUSY, 11, 16)); else passed++;
      clear_knobs();
      efp_at = 10;
      run_seq("efp_in_done", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 24);
      checks++; if (ekc_cnt !== 1 || cnt(R_BUSY, 11, 24) !== 0)
         $display("FAIL efp_in_done: got ekc %0d busy %0d want 1/0", ekc_cnt, cnt(R_BUSY, 11, 24)); else passed++;
      clear_knobs();
      efp_at = 11;
      run_seq("back_to_back", 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 24);
      checks++; if (rec[R_BUSY][11] !== 1'b0 || rec[R_BUSY][12] !== 1'b1 || rec[R_RLP][12] !== 1'b1)
         $display("FAIL b2b_restart: got busy %b/%b rlp %b want 0/1/1", rec[R_BUSY][11], rec[R_BUSY][12], rec[R_RLP][12]); else passed++;
      checks++; if (ekc_cnt !== 2 || rec[R_EKC][21] !== 1'b1)
         $display("FAIL b2b_ekc: got count %0d ekc@21 %b want 2/1", ekc_cnt, rec[R_EKC][21]); else passed++;
   endtask

   initial begin
      clr = 1'b1; efp = 1'b0; nrf = 1'b0; op = 2'b00; fwz = 1'b0;
      ok = 1'b0; nz = 1'b0; ovf = 1'b0;
      clear_knobs();
      test_reset();
      test_add_reg();
      test_fetch();
      test_mul();
      test_norm();
      test_zero();
      test_ovf();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
